// File: rtl/bcd_seg_driver.sv
// rtl/bcd_seg_driver.sv - binary to multi-digit 7-segment driver using shift-and-add-3 conversion
module bcd_seg_driver #(
  parameter int DATA_W = 5,
  parameter int DIGITS = 2,
  parameter int LZB    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     data,
  input  logic                  load,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int SH_W  = BCD_W + DATA_W;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [DATA_W-1:0]   r_bin;
  logic [BCD_W-1:0]    r_bcd;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_lost;
  logic [7*DIGITS-1:0] r_seg;
  logic                r_ovf;
  logic                r_done;

  logic [BCD_W-1:0]    w_bcd_adj;
  logic [SH_W-1:0]     w_shift;
  logic                w_last;
  logic [7*DIGITS-1:0] w_seg_new;
  logic                w_seen;
  logic [3:0]          w_nib;

  // Active-low digit glyphs, segment a in bit 6 down to g in bit 0
  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Add-3 correction on every BCD nibble that would exceed 9 after doubling
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_shift = {w_bcd_adj, r_bin} << 1;
  assign w_last  = (r_cnt == CNT_W'(DATA_W - 1));

  // Glyph selection: dashes on overflow, leading zeros blanked from the top down
  always_comb begin
    w_seg_new = '1;
    w_seen    = 1'b0;
    w_nib     = 4'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_nib = r_bcd[4*i +: 4];
      if (w_nib != 4'd0) begin
        w_seen = 1'b1;
      end
      if (r_lost) begin
        w_seg_new[7*i +: 7] = SEG_DASH;
      end else if ((LZB != 0) && (i != 0) && !w_seen) begin
        w_seg_new[7*i +: 7] = SEG_BLANK;
      end else begin
        w_seg_new[7*i +: 7] = digit_to_seg(w_nib);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; loads outside IDLE are dropped, not queued
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (load) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Conversion datapath and registered display outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_lost <= 1'b0;
      r_seg  <= '1;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load) begin
            r_bin  <= data;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_lost <= 1'b0;
          end
        end
        SHIFT: begin
          {r_bcd, r_bin} <= w_shift;
          r_cnt          <= r_cnt + CNT_W'(1);
          // A set top bit after correction means the value no longer fits in DIGITS digits
          if (w_bcd_adj[BCD_W-1]) begin
            r_lost <= 1'b1;
          end
        end
        DONE: begin
          r_seg  <= w_seg_new;
          r_ovf  <= r_lost;
          r_done <= 1'b1;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign seg  = r_seg;
  assign ovf  = r_ovf;
  assign done = r_done;
  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_bcd_seg_driver.sv
// tb/tb_bcd_seg_driver.sv - self-checking bench for bcd_seg_driver across four parameter sets
module tb_bcd_seg_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [4:0]  data5;
  logic [7:0]  data8;

  logic [13:0] seg0, seg1, seg3;
  logic [20:0] seg2;
  logic        busy0, busy1, busy2, busy3;
  logic        done0, done1, done2, done3;
  logic        ovf0, ovf1, ovf2, ovf3;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bcd_seg_driver #(.DATA_W(5), .DIGITS(2), .LZB(1)) u0 (
    .clk(clk), .rst_n(rst_n), .data(data5), .load(load),
    .seg(seg0), .busy(busy0), .done(done0), .ovf(ovf0));
  bcd_seg_driver #(.DATA_W(5), .DIGITS(2), .LZB(0)) u1 (
    .clk(clk), .rst_n(rst_n), .data(data5), .load(load),
    .seg(seg1), .busy(busy1), .done(done1), .ovf(ovf1));
  bcd_seg_driver #(.DATA_W(8), .DIGITS(3), .LZB(1)) u2 (
    .clk(clk), .rst_n(rst_n), .data(data8), .load(load),
    .seg(seg2), .busy(busy2), .done(done2), .ovf(ovf2));
  bcd_seg_driver #(.DATA_W(8), .DIGITS(2), .LZB(1)) u3 (
    .clk(clk), .rst_n(rst_n), .data(data8), .load(load),
    .seg(seg3), .busy(busy3), .done(done3), .ovf(ovf3));

  int m_dw  [4] = '{5, 5, 8, 8};
  int m_dig [4] = '{2, 2, 3, 2};
  int m_lzb [4] = '{1, 0, 1, 1};
  int          m_rem  [4];
  int          m_val  [4];
  logic [20:0] m_seg  [4];
  bit          m_ovf  [4];
  bit          m_done [4];

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int pow10(input int n);
    int p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [20:0] all_blank(input int dig);
    logic [20:0] m = '1;
    return m >> (21 - 7 * dig);
  endfunction

  // Expected display from decimal arithmetic on the captured value
  function automatic logic [20:0] model_seg(input int val, input int dig, input int lzb);
    logic [20:0] res = '0;
    bit over = (val >= pow10(dig));
    for (int i = 0; i < dig; i++) begin
      if (over) res[7*i +: 7] = 7'b1111110;
      else if (lzb != 0 && i > 0 && val < pow10(i)) res[7*i +: 7] = 7'b1111111;
      else res[7*i +: 7] = glyph((val / pow10(i)) % 10);
    end
    return res;
  endfunction

  // Model: busy for DATA_W+1 cycles after an accepted load, then show the new value
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        m_rem[i]  = 0;
        m_seg[i]  = all_blank(m_dig[i]);
        m_ovf[i]  = 1'b0;
        m_done[i] = 1'b0;
      end else begin
        m_done[i] = 1'b0;
        if (m_rem[i] == 0) begin
          if (load) begin
            m_val[i] = (i < 2) ? int'(data5) : int'(data8);
            m_rem[i] = m_dw[i] + 1;
          end
        end else begin
          m_rem[i] = m_rem[i] - 1;
          if (m_rem[i] == 0) begin
            m_seg[i]  = model_seg(m_val[i], m_dig[i], m_lzb[i]);
            m_ovf[i]  = (m_val[i] >= pow10(m_dig[i]));
            m_done[i] = 1'b1;
          end
        end
      end
    end
  end

  task automatic cmp_one(input int i, input logic [20:0] s, input logic b, input logic d, input logic o);
    check($sformatf("u%0d_seg", i),  s, m_seg[i]);
    check($sformatf("u%0d_busy", i), 21'(b), 21'(m_rem[i] != 0));
    check($sformatf("u%0d_done", i), 21'(d), 21'(m_done[i]));
    check($sformatf("u%0d_ovf", i),  21'(o), 21'(m_ovf[i]));
  endtask

  // Compare every DUT against the model on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_one(0, 21'(seg0), busy0, done0, ovf0);
      cmp_one(1, 21'(seg1), busy1, done1, ovf1);
      cmp_one(2, seg2,      busy2, done2, ovf2);
      cmp_one(3, 21'(seg3), busy3, done3, ovf3);
    end
  end

  task automatic convert(input logic [4:0] a, input logic [7:0] b);
    @(negedge clk);
    data5 = a;
    data8 = b;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    repeat (11) @(negedge clk);
  endtask

  task automatic wait_done0(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (done0) ok = 1'b1;
    end
  endtask

  int  n_done;
  bit  ok;

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    data5 = '0;
    data8 = '0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_seg0", 21'(seg0), 21'h3FFF);
    check("rst_seg2", seg2, 21'h1FFFFF);
    check("rst_busy0", 21'(busy0), 21'd0);
    check("rst_done0", 21'(done0), 21'd0);
    check("rst_ovf3", 21'(ovf3), 21'd0);
    @(negedge clk);
    rst_n = 1'b1;

    convert(5'd13, 8'd255);
    check("d13_u0", 21'(seg0), 21'({7'b1001111, 7'b0000110}));
    check("d13_u0_ovf", 21'(ovf0), 21'd0);
    check("d255_u2", seg2, {7'b0010010, 7'b0100100, 7'b0100100});
    check("d255_u3", 21'(seg3), 21'({7'b1111110, 7'b1111110}));
    check("d255_u3_ovf", 21'(ovf3), 21'd1);

    convert(5'd7, 8'd200);
    check("d7_u0", 21'(seg0), 21'({7'b1111111, 7'b0001111}));
    check("d7_u1", 21'(seg1), 21'({7'b0000001, 7'b0001111}));
    check("d200_u2", seg2, {7'b0010010, 7'b0000001, 7'b0000001});
    check("d200_u3", 21'(seg3), 21'({7'b1111110, 7'b1111110}));
    check("d200_u3_ovf", 21'(ovf3), 21'd1);

    convert(5'd0, 8'd0);
    check("d0_u0", 21'(seg0), 21'({7'b1111111, 7'b0000001}));
    check("d0_u1", 21'(seg1), 21'({7'b0000001, 7'b0000001}));
    check("d0_u2", seg2, {7'b1111111, 7'b1111111, 7'b0000001});
    check("d0_u3_ovf", 21'(ovf3), 21'd0);

    convert(5'd31, 8'd99);
    check("d31_u0", 21'(seg0), 21'({7'b0000110, 7'b1001111}));
    check("d99_u3", 21'(seg3), 21'({7'b0000100, 7'b0000100}));
    check("d99_u3_ovf", 21'(ovf3), 21'd0);

    // Latency: done on u0 exactly after the sixth edge following the load edge
    @(negedge clk);
    data5 = 5'd13;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("lat_done_k%0d", k), 21'(done0), 21'(k == 6));
      check($sformatf("lat_busy_k%0d", k), 21'(busy0), 21'(k < 6));
    end
    repeat (4) @(negedge clk);

    // Load held high; data changes during conversion must not affect it
    data5 = 5'd13;
    data8 = 8'd13;
    load  = 1'b1;
    repeat (2) @(negedge clk);
    data5 = 5'd9;
    wait_done0(ok);
    check("held_first_done", 21'(ok), 21'd1);
    check("held_first_seg", 21'(seg0), 21'({7'b1001111, 7'b0000110}));
    wait_done0(ok);
    check("held_second_done", 21'(ok), 21'd1);
    check("held_second_seg", 21'(seg0), 21'({7'b1111111, 7'b0000100}));
    load = 1'b0;
    repeat (12) @(negedge clk);

    // Reset during SHIFT aborts the conversion
    data5 = 5'd31;
    data8 = 8'd77;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    load  = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    load  = 1'b0;
    rst_n = 1'b1;
    check("abort_busy0", 21'(busy0), 21'd0);
    check("abort_seg0", 21'(seg0), 21'h3FFF);
    check("abort_seg2", seg2, 21'h1FFFFF);
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done0 || done1 || done2 || done3) n_done++;
    end
    check("abort_no_done", 21'(n_done), 21'd0);
    check("abort_seg0_held", 21'(seg0), 21'h3FFF);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bcd_seg_driver.md
BCD_SEG_DRIVER -- requirements
Module: bcd_seg_driver

Interface
REQ-001 Parameter DATA_W, default 5, width of the unsigned binary input value.
REQ-002 Parameter DIGITS, default 2, number of decimal 7-segment digits driven.
REQ-003 Parameter LZB, default 1, leading-zero blanking enable (1 = blank leading zeros).
REQ-004 Port clk  input  1  single clock; all state changes on rising edge.
REQ-005 Port rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port data  input  DATA_W  unsigned binary value to display, sampled only when a load is accepted.
REQ-007 Port load  input  1  conversion request, sampled each rising edge.
REQ-008 Port seg  output  7*DIGITS  segment patterns, digit i on seg[7*i+6:7*i], digit 0 least significant, active-low, bit order abcdefg with a as MSB.
REQ-009 Port busy  output  1  high while a conversion is in progress.
REQ-010 Port done  output  1  one-cycle pulse marking the first cycle with new seg contents.
REQ-011 Port ovf  output  1  high while the displayed value exceeds 10^DIGITS-1.

Function
REQ-012 Encoding SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, blank=1111111, dash=1111110.
REQ-013 FSM SHALL have states IDLE, SHIFT, DONE; busy = (state != IDLE), combinational from state.
REQ-014 IDLE: load=1 at an edge SHALL capture data, clear the 4*DIGITS-bit BCD register, clear the shift counter, and go to SHIFT.
REQ-015 SHIFT: each edge SHALL add 3 to every BCD nibble >= 5, then shift {BCD, binary} left one bit; after exactly DATA_W shifts go to DONE.
REQ-016 DONE: the next edge SHALL register seg, ovf, and done=1, then return to IDLE.
REQ-017 Latency: load accepted at edge E0 -> new seg and done=1 valid after edge E(DATA_W+1); done SHALL be low at all other times.
REQ-018 load while busy (SHIFT or DONE) SHALL be ignored with no queuing; load in IDLE in the cycle after done SHALL be accepted.
REQ-019 seg and ovf SHALL hold their previous values during conversion until the DONE update.
REQ-020 Overflow: if the captured value > 10^DIGITS-1, all digits SHALL show dash and ovf=1; otherwise ovf=0.
REQ-021 LZB=1: every digit above the most significant nonzero digit SHALL be blank; digit 0 SHALL always be shown, so value 0 displays "0".
REQ-022 LZB=0: all digits SHALL be shown, including leading zeros.
REQ-023 The design SHALL be correct for any DATA_W >= 1, DIGITS >= 1, including DATA_W with max value < 10^DIGITS (ovf never set).

Reset
REQ-024 rst_n=0 at an edge SHALL force IDLE, seg to all-blank (all ones), busy=0, done=0, ovf=0, regardless of state.
REQ-025 Reset mid-conversion SHALL abort it with no done pulse and no seg update; load during reset SHALL be ignored.

Verification
REQ-026 DATA_W=5, DIGITS=2, LZB=1: load data=13 -> done after 6 edges, seg[13:7]=1001111, seg[6:0]=0000110, ovf=0.
REQ-027 Same config: data=7 -> seg[13:7]=1111111, seg[6:0]=0001111; with LZB=0 -> seg[13:7]=0000001.
REQ-028 Same config, LZB=1: data=0 -> seg[13:7]=1111111, seg[6:0]=0000001.
REQ-029 DATA_W=8, DIGITS=3: data=255 -> digits 2,5,5 (0010010, 0100100, 0100100) after 9 edges; DIGITS=2, data=200 -> both digits 1111110, ovf=1.
REQ-030 load=1 held every cycle from data=13 with data changed to 9 mid-conversion -> 13 displayed, next conversion captures the value present in the IDLE cycle after done.
REQ-031 rst_n low for one edge during SHIFT -> busy=0, done never pulses, seg all 1111111.
